// File: rtl/rtc_alarm_ctrl.sv
// Alarm controller running on the RTC's 1 Hz clock (one cycle = one second).
// Compares the live HH:mm:ss against a stored HH:mm alarm and drives the
// ring output. It also handles snooze, stop, the ring timeout and a sticky
// "missed" flag.
module rtc_alarm_ctrl #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  HH,
  input  logic [5:0]  mm,
  input  logic [5:0]  ss,
  input  logic        alarm_en,
  input  logic        alarm_set,
  input  logic [10:0] alarm_time,
  input  logic        snooze,
  input  logic        stop,
  output logic        ring,
  output logic        snoozing,
  output logic        missed,
  output logic        set_err,
  output logic [1:0]  snooze_cnt,
  output logic [4:0]  alarm_hh,
  output logic [5:0]  alarm_mm
);

  localparam int SNOOZE_SECS = SNOOZE_MIN * 60;
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZED} state_t;

  state_t        state;
  logic [RW-1:0] ring_ctr;   // cycles ring has been high beyond the first
  logic [SW-1:0] snz_ctr;    // cycles spent in the current snooze beyond the first
  logic          set_ok;
  logic          trig;

  // An alarm load is only legal for a real clock time (00:00 .. 23:59).
  assign set_ok = (alarm_time[10:6] <= 5'd23) && (alarm_time[5:0] <= 6'd59);
  // Only the exact start of the alarm minute fires; jumping mid-minute does not.
  assign trig   = (HH == alarm_hh) && (mm == alarm_mm) && (ss == 6'd0);

  // Alarm time storage and one-cycle rejection pulse, independent of the session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_hh <= '0;
      alarm_mm <= '0;
      set_err  <= 1'b0;
    end else begin
      set_err <= alarm_set && !set_ok;
      if (alarm_set && set_ok) begin
        alarm_hh <= alarm_time[10:6];
        alarm_mm <= alarm_time[5:0];
      end
    end
  end

  // Session FSM: arming, ringing with timeout, snooze countdown, stop handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DISARMED;
      ring       <= 1'b0;
      snoozing   <= 1'b0;
      missed     <= 1'b0;
      snooze_cnt <= '0;
      ring_ctr   <= '0;
      snz_ctr    <= '0;
    end else if (!alarm_en) begin
      // Disarming overrides everything; missed is deliberately left alone.
      state      <= DISARMED;
      ring       <= 1'b0;
      snoozing   <= 1'b0;
      snooze_cnt <= '0;
      ring_ctr   <= '0;
      snz_ctr    <= '0;
    end else begin
      case (state)
        DISARMED: state <= ARMED;
        ARMED: begin
          if (trig) begin
            state    <= RINGING;
            ring     <= 1'b1;
            ring_ctr <= '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state      <= ARMED;
            ring       <= 1'b0;
            snooze_cnt <= '0;
            missed     <= 1'b0;
          end else if (snooze && (snooze_cnt < SNZ_MAX)) begin
            state      <= SNOOZED;
            ring       <= 1'b0;
            snoozing   <= 1'b1;
            snooze_cnt <= snooze_cnt + 2'd1;
            snz_ctr    <= '0;
          end else if (ring_ctr == RING_LAST) begin
            state      <= ARMED;
            ring       <= 1'b0;
            missed     <= 1'b1;
            snooze_cnt <= '0;
          end else begin
            ring_ctr <= ring_ctr + RW'(1);
          end
        end
        SNOOZED: begin
          if (stop) begin
            state      <= ARMED;
            snoozing   <= 1'b0;
            snooze_cnt <= '0;
            missed     <= 1'b0;
          end else if (snz_ctr == SNZ_LAST) begin
            state    <= RINGING;
            snoozing <= 1'b0;
            ring     <= 1'b1;
            ring_ctr <= '0;
          end else begin
            snz_ctr <= snz_ctr + SW'(1);
          end
        end
        default: state <= DISARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Testbench for rtc_alarm_ctrl: directed scenarios plus randomized traffic,
// all checked against a countdown-based behavioural model of the alarm rules.
module tb_rtc_alarm_ctrl;

  localparam int RING_SECS  = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;
  localparam int OFF = 0, ARM = 1, RNG = 2, SNZ = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  HH;
  logic [5:0]  mm, ss;
  logic        alarm_en, alarm_set, snooze, stop;
  logic [10:0] alarm_time;
  logic        ring, snoozing, missed, set_err;
  logic [1:0]  snooze_cnt;
  logic [4:0]  alarm_hh;
  logic [5:0]  alarm_mm;
  logic [16:0] got_v;

  int checks = 0;
  int errors = 0;

  // Behavioural model: activity mode plus seconds remaining in the current phase.
  int m_mode, m_left, m_cnt, m_hh, m_mm;
  bit m_missed, m_err;

  always #5 clk = ~clk;

  rtc_alarm_ctrl #(.RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)) dut (
    .clk(clk), .rst(rst), .HH(HH), .mm(mm), .ss(ss), .alarm_en(alarm_en),
    .alarm_set(alarm_set), .alarm_time(alarm_time), .snooze(snooze), .stop(stop),
    .ring(ring), .snoozing(snoozing), .missed(missed), .set_err(set_err),
    .snooze_cnt(snooze_cnt), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm)
  );

  assign got_v = {ring, snoozing, missed, set_err, snooze_cnt, alarm_hh, alarm_mm};

  function automatic logic [16:0] exp_v();
    return {m_mode == RNG, m_mode == SNZ, m_missed, m_err, 2'(m_cnt), 5'(m_hh), 6'(m_mm)};
  endfunction

  task automatic model_reset();
    m_mode = OFF; m_left = 0; m_cnt = 0; m_hh = 0; m_mm = 0; m_missed = 0; m_err = 0;
  endtask

  task automatic model_step();
    int old_hh, old_mm;
    bit ok;
    old_hh = m_hh;
    old_mm = m_mm;
    ok = (alarm_time[10:6] <= 23) && (alarm_time[5:0] <= 59);
    m_err = alarm_set && !ok;
    if (alarm_set && ok) begin
      m_hh = int'(alarm_time[10:6]);
      m_mm = int'(alarm_time[5:0]);
    end
    if (!alarm_en) begin
      m_mode = OFF; m_cnt = 0;
    end else if (m_mode == OFF) begin
      m_mode = ARM;
    end else if (m_mode == ARM) begin
      if (int'(HH) == old_hh && int'(mm) == old_mm && ss == 0) begin
        m_mode = RNG; m_left = RING_SECS;
      end
    end else if (m_mode == RNG) begin
      if (stop) begin
        m_mode = ARM; m_cnt = 0; m_missed = 0;
      end else if (snooze && m_cnt < MAX_SNOOZE) begin
        m_mode = SNZ; m_cnt = m_cnt + 1; m_left = SNOOZE_MIN * 60;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = ARM; m_missed = 1; m_cnt = 0;
        end
      end
    end else begin
      if (stop) begin
        m_mode = ARM; m_cnt = 0; m_missed = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = RNG; m_left = RING_SECS;
        end
      end
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    HH = 5'(h); mm = 6'(m); ss = 6'(s);
  endtask

  // One clock: inputs are already driven; model follows the same edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    alarm_set = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  // Show the stored alarm minute at ss=0 for one cycle, then move away.
  task automatic fire();
    set_time(7, 30, 0);
    step();
    set_time(8, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; alarm_en = 1'b0; alarm_set = 1'b0; alarm_time = '0;
    snooze = 1'b0; stop = 1'b0; set_time(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_v !== 17'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", got_v, 17'd0); end
    rst = 1'b0;
    step();
    checks++;
    if (got_v !== exp_v()) begin errors++; $display("FAIL reset_idle got=%h exp=%h", got_v, exp_v()); end
  endtask

  task automatic test_trigger();
    alarm_time = {5'd7, 6'd30}; alarm_set = 1'b1; set_time(7, 0, 0);
    step();
    checks++;
    if ({alarm_hh, alarm_mm} !== {5'd7, 6'd30}) begin
      errors++; $display("FAIL load_0730 got=%h exp=%h", {alarm_hh, alarm_mm}, {5'd7, 6'd30});
    end
    alarm_en = 1'b1;
    step();
    set_time(7, 29, 59);
    step();
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL ring_before_alarm got=%b exp=0", ring); end
    set_time(7, 30, 0);
    step();
    checks++;
    if (ring !== 1'b1 || snooze_cnt !== 2'd0) begin
      errors++; $display("FAIL trigger got ring=%b cnt=%0d exp ring=1 cnt=0", ring, snooze_cnt);
    end
    set_time(8, 0, 0);
    checks++;
    if (got_v !== exp_v()) begin errors++; $display("FAIL trigger_model got=%h exp=%h", got_v, exp_v()); end
  endtask

  task automatic test_timeout();
    int high;
    high = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (got_v !== exp_v()) begin errors++; $display("FAIL timeout_track got=%h exp=%h", got_v, exp_v()); end
      if (ring) high++;
      else break;
    end
    checks++;
    if (high != RING_SECS || missed !== 1'b1) begin
      errors++; $display("FAIL timeout_len got high=%0d missed=%b exp high=%0d missed=1", high, missed, RING_SECS);
    end
    fire();
    stop = 1'b1;
    step();
    checks++;
    if (ring !== 1'b0 || missed !== 1'b0) begin
      errors++; $display("FAIL stop_clears_missed got ring=%b missed=%b exp 0 0", ring, missed);
    end
  endtask

  task automatic test_snooze();
    int low;
    fire();
    for (int k = 1; k <= MAX_SNOOZE; k++) begin
      snooze = 1'b1;
      step();
      checks++;
      if (ring !== 1'b0 || snoozing !== 1'b1 || snooze_cnt !== 2'(k)) begin
        errors++; $display("FAIL snooze_enter got ring=%b snz=%b cnt=%0d exp 0 1 %0d", ring, snoozing, snooze_cnt, k);
      end
      low = 1;
      for (int i = 0; i < 400; i++) begin
        step();
        checks++;
        if (got_v !== exp_v()) begin errors++; $display("FAIL snooze_track got=%h exp=%h", got_v, exp_v()); end
        if (!ring) low++;
        else break;
      end
      checks++;
      if (low != SNOOZE_MIN * 60) begin
        errors++; $display("FAIL snooze_len got=%0d exp=%0d", low, SNOOZE_MIN * 60);
      end
    end
    snooze = 1'b1;
    step();
    checks++;
    if (ring !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 2'd3) begin
      errors++; $display("FAIL snooze_limit got ring=%b snz=%b cnt=%0d exp 1 0 3", ring, snoozing, snooze_cnt);
    end
    stop = 1'b1;
    step();
    checks++;
    if (got_v !== exp_v()) begin errors++; $display("FAIL snooze_stop got=%h exp=%h", got_v, exp_v()); end
  endtask

  task automatic test_stop_snooze_same();
    fire();
    stop = 1'b1; snooze = 1'b1;
    step();
    checks++;
    if (ring !== 1'b0 || snoozing !== 1'b0 || snooze_cnt !== 2'd0) begin
      errors++; $display("FAIL stop_wins got ring=%b snz=%b cnt=%0d exp 0 0 0", ring, snoozing, snooze_cnt);
    end
  endtask

  task automatic test_set_err();
    logic [10:0] bad [2];
    bad[0] = {5'd24, 6'd0};
    bad[1] = {5'd12, 6'd60};
    for (int b = 0; b < 2; b++) begin
      alarm_time = bad[b]; alarm_set = 1'b1;
      step();
      checks++;
      if (set_err !== 1'b1 || {alarm_hh, alarm_mm} !== {5'd7, 6'd30}) begin
        errors++; $display("FAIL set_err_pulse got err=%b alarm=%h exp err=1 alarm=%h", set_err, {alarm_hh, alarm_mm}, {5'd7, 6'd30});
      end
      step();
      checks++;
      if (set_err !== 1'b0) begin errors++; $display("FAIL set_err_width got=%b exp=0", set_err); end
    end
    fire();
    alarm_en = 1'b0;
    step();
    checks++;
    if (ring !== 1'b0 || got_v !== exp_v()) begin
      errors++; $display("FAIL disarm_mid_ring got=%h exp=%h", got_v, exp_v());
    end
    // Re-enable exactly on the alarm second: a disarmed controller must not fire yet.
    alarm_en = 1'b1; set_time(7, 30, 0);
    step();
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL disarmed_no_trigger got=%b exp=0", ring); end
    set_time(8, 0, 0);
    step();
  endtask

  task automatic test_async_reset();
    fire();
    repeat (RING_SECS) step();
    stop = 1'b1;
    step();
    checks++;
    if (missed !== 1'b1) begin errors++; $display("FAIL stop_armed_keeps_missed got=%b exp=1", missed); end
    fire();
    snooze = 1'b1;
    step();
    repeat (10) step();
    checks++;
    if (snoozing !== 1'b1 || got_v !== exp_v()) begin
      errors++; $display("FAIL pre_reset_snoozed got=%h exp=%h", got_v, exp_v());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (got_v !== 17'd0) begin errors++; $display("FAIL async_reset got=%h exp=%h", got_v, 17'd0); end
    model_reset();
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int t, base, h, m;
    t = 7 * 3600 + 25 * 60;
    for (int i = 0; i < 6000; i++) begin
      alarm_en = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 199) == 0) begin
        h = $urandom_range(0, 27); m = $urandom_range(0, 63);
        alarm_time = {5'(h), 6'(m)}; alarm_set = 1'b1;
      end
      snooze = ($urandom_range(0, 59) == 0);
      stop   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 89) == 0) begin
        base = m_hh * 3600 + m_mm * 60;
        t = (base + $urandom_range(0, 4) - 2 + 86400) % 86400;
      end else begin
        t = (t + 1) % 86400;
      end
      set_time(t / 3600, (t / 60) % 60, t % 60);
      step();
      checks++;
      if (got_v !== exp_v()) begin errors++; $display("FAIL random_cycle%0d got=%h exp=%h", i, got_v, exp_v()); end
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_timeout();
    test_snooze();
    test_stop_snooze_same();
    test_set_err();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
